// File: rtl/mem_arbiter_rr_if.sv
// Bus bundle between the core array, the round-robin memory arbiter and the shared RAM.
// The arbiter uses the slave view; the core/RAM side uses the master view.
interface mem_arbiter_rr_if #(
    parameter int NCORES = 4,
    parameter int AW     = 8,
    parameter int DW     = 8
);
    logic [NCORES-1:0]    rden;
    logic [NCORES-1:0]    wren;
    logic [NCORES*AW-1:0] Address;
    logic [NCORES*DW-1:0] Din;
    logic [NCORES-1:0]    acq;
    logic [NCORES-1:0]    rsp_valid;
    logic [NCORES*DW-1:0] Dq;
    logic [DW-1:0]        RAMq;
    logic [AW-1:0]        RAMAddress;
    logic [DW-1:0]        RAMDin;
    logic                 RAMwren;

    modport slave (
        input  rden, wren, Address, Din, RAMq,
        output acq, rsp_valid, Dq, RAMAddress, RAMDin, RAMwren
    );

    modport master (
        output rden, wren, Address, Din, RAMq,
        input  acq, rsp_valid, Dq, RAMAddress, RAMDin, RAMwren
    );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter of NCORES cores onto one single-port synchronous RAM, with a per-grant
// hold limit and a tagged read-return pipeline feeding per-core response registers.
module mem_arbiter_rr #(
    parameter int NCORES   = 4,
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_arbiter_rr_if.slave  bus
);
    localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [NCORES-1:0] ONE_HOT0 = {{(NCORES-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t              state_r, state_s;
    logic [IW-1:0]       owner_r, owner_s;
    logic [IW-1:0]       last_r, last_s;
    logic [HW-1:0]       hold_cnt_r, hold_cnt_s, hold_inc_s;
    logic [NCORES-1:0]   acq_r, acq_s;
    logic [NCORES-1:0]   req_s, others_s;
    logic [IW:0]         pick_s;
    logic                access_s, rd_access_s, limit_s;

    logic [AW-1:0]        ram_addr_r;
    logic [DW-1:0]        ram_din_r;
    logic                 ram_wren_r;
    logic                 tag1_v_r, tag2_v_r;
    logic [IW-1:0]        tag1_id_r, tag2_id_r;
    logic [NCORES-1:0]    rsp_valid_r;
    logic [NCORES*DW-1:0] dq_r;

    // First requester scanning upward from base+1, wrapping; MSB flags that one was found.
    function automatic logic [IW:0] rr_pick(input logic [NCORES-1:0] r, input logic [IW-1:0] base);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int i = 1; i <= NCORES; i++) begin
            idx = (int'(base) + i) % NCORES;
            if (!res[IW] && r[IW'(idx)]) begin
                res = {1'b1, IW'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Next-state, grant and access decode
    always_comb begin
        state_s     = state_r;
        owner_s     = owner_r;
        last_s      = last_r;
        hold_cnt_s  = hold_cnt_r;
        acq_s       = acq_r;
        access_s    = 1'b0;
        limit_s     = 1'b0;
        pick_s      = '0;
        req_s       = bus.rden | bus.wren;
        others_s    = req_s & ~(ONE_HOT0 << owner_r);
        hold_inc_s  = hold_cnt_r + 1'b1;
        case (state_r)
            IDLE: begin
                pick_s = rr_pick(req_s, last_r);
                if (pick_s[IW]) begin
                    state_s    = OWN;
                    owner_s    = pick_s[IW-1:0];
                    hold_cnt_s = '0;
                    acq_s      = ONE_HOT0 << pick_s[IW-1:0];
                end else begin
                    acq_s      = '0;
                end
            end
            OWN: begin
                access_s = req_s[owner_r];
                limit_s  = (MAX_HOLD != 0) && access_s && (hold_inc_s == HW'(MAX_HOLD));
                pick_s   = rr_pick(others_s, owner_r);
                if (!access_s || (limit_s && pick_s[IW])) begin
                    last_s     = owner_r;
                    hold_cnt_s = '0;
                    if (pick_s[IW]) begin
                        owner_s = pick_s[IW-1:0];
                        acq_s   = ONE_HOT0 << pick_s[IW-1:0];
                    end else begin
                        state_s = IDLE;
                        acq_s   = '0;
                    end
                end else if (limit_s) begin
                    hold_cnt_s = '0;
                end else begin
                    hold_cnt_s = hold_inc_s;
                end
            end
            default: begin
                state_s = IDLE;
                acq_s   = '0;
            end
        endcase
        rd_access_s = access_s & bus.rden[owner_r] & ~bus.wren[owner_r];
    end

    // Arbitration state and grant register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            owner_r    <= '0;
            last_r     <= IW'(NCORES - 1);
            hold_cnt_r <= '0;
            acq_r      <= '0;
        end else begin
            state_r    <= state_s;
            owner_r    <= owner_s;
            last_r     <= last_s;
            hold_cnt_r <= hold_cnt_s;
            acq_r      <= acq_s;
        end
    end

    // RAM command registers; address/data hold when no access issues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr_r <= '0;
            ram_din_r  <= '0;
            ram_wren_r <= 1'b0;
        end else begin
            ram_wren_r <= access_s & bus.wren[owner_r];
            if (access_s) begin
                ram_addr_r <= bus.Address[int'(owner_r)*AW +: AW];
                ram_din_r  <= bus.Din[int'(owner_r)*DW +: DW];
            end
        end
    end

    // Tag pipe routes RAM read data to the core that issued the read, whoever owns the bus now
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag1_v_r    <= 1'b0;
            tag1_id_r   <= '0;
            tag2_v_r    <= 1'b0;
            tag2_id_r   <= '0;
            rsp_valid_r <= '0;
            dq_r        <= '0;
        end else begin
            tag1_v_r    <= rd_access_s;
            tag1_id_r   <= owner_r;
            tag2_v_r    <= tag1_v_r;
            tag2_id_r   <= tag1_id_r;
            rsp_valid_r <= '0;
            if (tag2_v_r) begin
                rsp_valid_r[tag2_id_r]              <= 1'b1;
                dq_r[int'(tag2_id_r)*DW +: DW]      <= bus.RAMq;
            end
        end
    end

    assign bus.acq        = acq_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.Dq         = dq_r;
    assign bus.RAMAddress = ram_addr_r;
    assign bus.RAMDin     = ram_din_r;
    assign bus.RAMwren    = ram_wren_r;
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Self-checking bench for mem_arbiter_rr: directed test-plan steps followed by random core
// traffic, all checked every cycle against a transaction-level arbitration/memory model.
module tb_mem_arbiter_rr;
    localparam int NC = 4, AW = 8, DW = 8, MAXH = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_rr_if #(.NCORES(NC), .AW(AW), .DW(DW)) bus();
    mem_arbiter_rr #(.NCORES(NC), .AW(AW), .DW(DW), .MAX_HOLD(MAXH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Synchronous RAM; unwritten locations read as addr ^ 0x4F
    logic [7:0] ram [256];
    bit         ram_w [256];
    always @(posedge clk) begin
        if (bus.RAMwren) begin
            ram[bus.RAMAddress]   <= bus.RAMDin;
            ram_w[bus.RAMAddress] <= 1'b1;
        end
        bus.RAMq <= ram_w[bus.RAMAddress] ? ram[bus.RAMAddress] : (bus.RAMAddress ^ 8'h4F);
    end

    int n_tests = 0, n_fail = 0, cyc = 0;
    bit random_mode = 1'b0;

    bit         j_act [NC];
    int         j_kind [NC];   // 0 read, 1 write, 2 read+write
    logic [7:0] j_addr [NC];
    logic [7:0] j_data [NC];
    int         j_cnt [NC];

    logic [7:0] mem_ref [256];
    bit         m_own;
    int         m_owner, m_last, m_hold;
    logic [7:0] m_raddr, m_rdin;
    logic       m_rwren;
    logic [31:0] m_dq;
    int         rq_core [$];
    logic [7:0] rq_data [$];
    int         rq_due [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int from, input int excl);
        for (int i = 1; i <= NC; i++) begin
            int c;
            c = (from + i) % NC;
            if (c != excl && r[c]) return c;
        end
        return -1;
    endfunction

    task automatic set_job(input int k, input int kind, input logic [7:0] a, input logic [7:0] d, input int n);
        j_act[k] = 1'b1; j_kind[k] = kind; j_addr[k] = a; j_data[k] = d; j_cnt[k] = n;
    endtask

    task automatic clear_jobs();
        for (int k = 0; k < NC; k++) j_act[k] = 1'b0;
    endtask

    task automatic model_reset();
        m_own = 1'b0; m_owner = 0; m_last = NC - 1; m_hold = 0;
        m_raddr = 8'h00; m_rdin = 8'h00; m_rwren = 1'b0; m_dq = 32'h0;
        rq_core.delete(); rq_data.delete(); rq_due.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_acq"}, 64'(bus.acq), 64'h0);
        chk({tag, "_rsp"}, 64'(bus.rsp_valid), 64'h0);
        chk({tag, "_wren"}, 64'(bus.RAMwren), 64'h0);
        chk({tag, "_addr"}, 64'(bus.RAMAddress), 64'h0);
        chk({tag, "_din"}, 64'(bus.RAMDin), 64'h0);
        chk({tag, "_dq"}, 64'(bus.Dq), 64'h0);
    endtask

    // Asynchronous reset asserted mid-cycle, held over one edge, released mid-cycle
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One clock: drive cores, predict the edge, then compare every output
    task automatic step();
        logic [3:0] r, exp_rsp;
        int acc, c, h;
        bit lim;
        for (int k = 0; k < NC; k++) begin
            bus.rden[k] = j_act[k] && (j_kind[k] != 1);
            bus.wren[k] = j_act[k] && (j_kind[k] != 0);
            bus.Address[k*AW +: AW] = j_addr[k];
            bus.Din[k*DW +: DW] = j_data[k];
        end
        r = bus.rden | bus.wren;
        acc = -1;
        m_rwren = 1'b0;
        if (!m_own) begin
            c = pick(r, m_last, -1);
            if (c >= 0) begin m_own = 1'b1; m_owner = c; m_hold = 0; end
        end else begin
            if (r[m_owner]) acc = m_owner;
            h = m_hold + ((acc >= 0) ? 1 : 0);
            lim = (MAXH != 0) && (acc >= 0) && (h == MAXH);
            c = pick(r, m_owner, m_owner);
            if (acc < 0 || (lim && c >= 0)) begin
                m_last = m_owner;
                if (c >= 0) begin m_owner = c; m_hold = 0; end
                else m_own = 1'b0;
            end else begin
                m_hold = lim ? 0 : h;
            end
        end
        if (acc >= 0) begin
            m_raddr = j_addr[acc];
            m_rdin  = j_data[acc];
            m_rwren = (j_kind[acc] != 0);
            if (m_rwren) mem_ref[m_raddr] = j_data[acc];
            else begin
                rq_core.push_back(acc); rq_data.push_back(mem_ref[m_raddr]); rq_due.push_back(cyc + 3);
            end
        end
        @(posedge clk); #1;
        cyc++;
        exp_rsp = 4'b0000;
        while (rq_due.size() > 0 && rq_due[0] == cyc) begin
            exp_rsp[rq_core[0]] = 1'b1;
            m_dq[rq_core[0]*DW +: DW] = rq_data[0];
            void'(rq_core.pop_front()); void'(rq_data.pop_front()); void'(rq_due.pop_front());
        end
        chk("acq", 64'(bus.acq), 64'(m_own ? (4'b0001 << m_owner) : 4'b0000));
        chk("RAMwren", 64'(bus.RAMwren), 64'(m_rwren));
        chk("RAMAddress", 64'(bus.RAMAddress), 64'(m_raddr));
        chk("RAMDin", 64'(bus.RAMDin), 64'(m_rdin));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rsp));
        chk("Dq", 64'(bus.Dq), 64'(m_dq));
        if (acc >= 0) begin
            j_cnt[acc]--; j_addr[acc]++; j_data[acc]++;
            if (j_cnt[acc] == 0) j_act[acc] = 1'b0;
        end
        if (random_mode) begin
            for (int k = 0; k < NC; k++) begin
                if (!j_act[k] && $urandom_range(0, 2) == 0)
                    set_job(k, int'($urandom_range(0, 2)), 8'($urandom), 8'($urandom), int'($urandom_range(1, 6)));
            end
        end
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        bus.rden = '0; bus.wren = '0; bus.Address = '0; bus.Din = '0;
        for (int i = 0; i < 256; i++) mem_ref[i] = 8'(i) ^ 8'h4F;
        clear_jobs();
        #3;
        do_reset();

        // Core 2 reads 0x15 (holds 0x5A)
        set_job(2, 0, 8'h15, 8'h00, 1);
        step(); chk("t1_grant", 64'(bus.acq), 64'h4);
        step(); chk("t1_addr", 64'(bus.RAMAddress), 64'h15);
        step();
        step(); chk("t1_rsp", 64'(bus.rsp_valid), 64'h4);
        chk("t1_dq", 64'(bus.Dq[23:16]), 64'h5A);
        for (int i = 0; i < 3; i++) step();

        // All four cores continuous, rotation every 2 accesses with no gap
        do_reset();
        for (int k = 0; k < NC; k++) set_job(k, 0, 8'(8'h90 + k * 16), 8'h00, 8);
        for (int e = 1; e <= 16; e++) begin
            step();
            chk("t2_rotate", 64'(bus.acq), 64'(4'b0001 << (((e - 1) / 2) % 4)));
        end
        for (int i = 0; i < 24; i++) step();

        // Core 0 read+write: write only, no response
        do_reset();
        set_job(0, 2, 8'h07, 8'h33, 1);
        step(); chk("t3_grant", 64'(bus.acq), 64'h1);
        step(); chk("t3_wren", 64'(bus.RAMwren), 64'h1);
        chk("t3_din", 64'(bus.RAMDin), 64'h33);
        chk("t3_addr", 64'(bus.RAMAddress), 64'h07);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin step(); cnt += int'(bus.RAMwren) + int'(|bus.rsp_valid); end
        chk("t3_quiet", 64'(cnt), 64'h0);

        // Core 1 reads then drops; core 3 takes over; data still reaches core 1
        set_job(1, 0, 8'h40, 8'h00, 1);
        set_job(3, 0, 8'h41, 8'h00, 1);
        step(); chk("t4_grant1", 64'(bus.acq), 64'h2);
        step();
        step(); chk("t4_grant3", 64'(bus.acq), 64'h8);
        step(); chk("t4_rsp1", 64'(bus.rsp_valid), 64'h2);
        chk("t4_dq1", 64'(bus.Dq[15:8]), 64'h0F);
        step();
        step(); chk("t4_rsp3", 64'(bus.rsp_valid), 64'h8);
        for (int i = 0; i < 3; i++) step();

        // Single requester, 10 reads, grant held through hold-limit wraps
        set_job(2, 0, 8'h80, 8'h00, 10);
        cnt = 0;
        for (int e = 1; e <= 14; e++) begin
            step();
            if (e <= 11) chk("t5_hold", 64'(bus.acq), 64'h4);
            cnt += int'(bus.rsp_valid[2]);
        end
        chk("t5_rsp_count", 64'(cnt), 64'd10);

        // Reset between a read's access and its response
        set_job(1, 0, 8'h21, 8'h00, 1);
        step(); chk("t6_grant", 64'(bus.acq), 64'h2);
        step();
        #2;
        do_reset();
        clear_jobs();
        set_job(0, 0, 8'h30, 8'h00, 1);
        set_job(3, 0, 8'h31, 8'h00, 1);
        step(); chk("t6_first_grant", 64'(bus.acq), 64'h1);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin step(); cnt += int'(bus.rsp_valid[1]); end
        chk("t6_dropped", 64'(cnt), 64'h0);

        // Random traffic
        random_mode = 1'b1;
        for (int i = 0; i < 400; i++) step();
        random_mode = 1'b0;
        clear_jobs();
        for (int i = 0; i < 6; i++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

- Parametrised successor to the two-core memory controller.
- Arbitrates `NCORES` cores onto one single-port synchronous RAM.
- Uses round-robin grants with a per-grant hold limit, so no core can starve another.
- Read data returns through a tagged pipeline into per-core response registers, so responses reach the right core even after ownership moves. Sits between the core array and the shared data RAM.

## Interface
- `NCORES`, 4: number of requesting cores (≥2).
- `AW`, 8: RAM address width.
- `DW`, 8: RAM data width.
- `MAX_HOLD`, 8: maximum accesses per grant while another core waits; 0 = unlimited.

- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rden`  in  NCORES  per-core read request.
- `wren`  in  NCORES  per-core write request.
- `Address`  in  NCORES*AW  per-core address; core k in bits [k*AW +: AW].
- `Din`  in  NCORES*DW  per-core write data; core k in bits [k*DW +: DW].
- `acq`  out  NCORES  registered grant, one-hot or zero.
- `rsp_valid`  out  NCORES  one-cycle read-data-valid pulse per core.
- `Dq`  out  NCORES*DW  per-core read data register; holds last value.
- `RAMq`  in  DW  RAM read data, valid the cycle after RAM samples `RAMAddress`.
- `RAMAddress`  out  AW  registered RAM address.
- `RAMDin`  out  DW  registered RAM write data.
- `RAMwren`  out  1  registered write strobe, one cycle per write.

## Operation
- `req[k] = rden[k] | wren[k]`.
- State `IDLE`, `acq` = 0:
  - If any `req` is high, select the first requester scanning from `last+1` mod `NCORES` upward.
  - Next edge: `acq[sel]`=1, `owner`=`sel`, `hold_cnt`=0, state `OWN`.
- State `OWN`: an access issues at an edge where `req[owner]`=1.
  - `RAMAddress`/`RAMDin` ← owner slices.
  - `RAMwren` ← `wren[owner]`.
  - `hold_cnt`++.
  - `wren` and `rden` both high: write only, no read response.
  - A read pushes tag {valid, owner} into a 2-stage tag pipe.
- No access at an edge: `RAMwren` ← 0; `RAMAddress`/`RAMDin` hold.
- Release at an edge in `OWN` when either condition holds:
  - (a) `req[owner]`=0.
  - (b) `MAX_HOLD`≠0, this edge's access makes `hold_cnt`=`MAX_HOLD`, and another core requests.
- Under (b) the final access still issues.
- On release:
  - `last` ← `owner`.
  - If another request is pending (scan from `owner+1`), grant moves to it on the same edge: no idle cycle, `hold_cnt`=0.
  - Otherwise state → `IDLE`, `acq` → 0.
- Hold limit reached with no other requester: `hold_cnt` ← 0, owner keeps grant.
- Response path: at tag stage 2 with valid set, `Dq[tag]` ← `RAMq` and `rsp_valid[tag]` pulses.
  - Independent of the current owner.
  - Read results survive grant changes.
- `hold_cnt` width is clog2(`MAX_HOLD`+1). Saturating logic is not needed because the counter clears at `MAX_HOLD`.

## Timing
- Reset (async assert, any state, mid-access included):
  - `acq`, `rsp_valid`, `RAMwren`, `RAMAddress`, `RAMDin`, `Dq` = 0.
  - Tag pipe cleared; in-flight reads are dropped, no `rsp_valid`.
  - State `IDLE`, `last`=`NCORES`-1 (core 0 first priority).
- Grant latency: request visible before edge E → `acq` high after E.
- First access samples at E+1; RAM outputs update after E+1.
- Read latency: access edge A → `rsp_valid` high in the cycle after edge A+2, exactly one cycle.
- Throughput: one access per cycle while the owner holds `req`; back-to-back reads return in order.
- Cores must hold `Address`/`Din`/`req` stable until a cycle in which `acq[k]`=1 at the edge. A request seen without `acq` is not an access.
- Ownership change: old owner's `acq` falls and new owner's `acq` rises on the same edge.

## Test plan
- Reset then core 2 reads addr 0x15 (RAM model holds 0x5A):
  - `acq`=0100 after 1 edge.
  - `RAMAddress`=0x15 after 2 edges.
  - `rsp_valid[2]` pulse and `Dq` core-2 slice = 0x5A after 4 edges.
- All 4 cores request continuously, `MAX_HOLD`=2:
  - Grants rotate 0→1→2→3→0, each owner making exactly 2 accesses.
  - Grant switches with no gap.
- Core 0 writes 0x33 to 0x07 with `rden`=`wren`=1:
  - one `RAMwren` pulse with `RAMDin`=0x33.
  - No `rsp_valid`.
- Core 1 issues a read, then drops its request; core 3 is granted next edge:
  - Core 1's data still arrives on `rsp_valid[1]`, not on core 3.
- Single requester, `MAX_HOLD`=2, 10 consecutive reads:
  - `acq` never drops.
  - 10 `rsp_valid` pulses in order.
- Assert `rst_n` low between a read's access edge and its response:
  - All outputs 0 immediately.
  - No `rsp_valid` after release.
  - First grant after reset goes to core 0 when cores 0 and 3 request together.
